// File: rtl/risc_pkg.sv
// Shared types for the 16-bit RISC core control path.
package risc_pkg;

   localparam int unsigned DATA_W = 16;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StMem    = 3'd4,
      StWb     = 3'd5,
      StHalt   = 3'd6,
      StError  = 3'd7
   } state_e;

   typedef struct packed {
      logic memr;
      logic memw;
      logic regw_en;
      logic upd_flag;
      logic b;
      logic jmp;
      logic hlt;
   } ctl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MEM-state stall cycles; expired flags the stall that brings the count to LIMIT.
module mem_wait_timer
   import risc_pkg::*;
#(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam logic [DATA_W-1:0] LimitW = LIMIT[DATA_W-1:0];

   logic [DATA_W-1:0] cnt_q, cnt_d, cnt_inc;

   assign cnt_inc = cnt_q + {{(DATA_W-1){1'b0}}, 1'b1};

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_inc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Flag on the stall cycle itself so the FSM leaves MEM right after the LIMIT-th stall.
   assign expired = en && !clear && (LIMIT != 32'd0) && (cnt_inc == LimitW);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer issuing datapath write enables.
module multicycle_sequencer
   import risc_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memr,
   input  logic              memw,
   input  logic              regw_en,
   input  logic              upd_flag,
   input  logic              b,
   input  logic              jmp,
   input  logic              hlt,
   input  logic              mem_ready,
   input  logic              resume,
   output logic              ir_we,
   output logic              pc_we,
   output logic              rf_we,
   output logic              flag_we,
   output logic              mem_req,
   output logic              mem_we,
   output logic              halted,
   output logic              error,
   output logic [2:0]        state,
   output logic [DATA_W-1:0] instr_count
);

   state_e            state_q, state_d;
   ctl_t              ctl_q, ctl_d;
   logic [DATA_W-1:0] count_q;
   logic              tmo_clear, tmo_en, tmo_expired;
   logic              unused_ctl;

   mem_wait_timer #(
      .LIMIT(MEM_TIMEOUT)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (tmo_clear),
      .en     (tmo_en),
      .expired(tmo_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         ctl_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         ctl_q   <= ctl_d;
         count_q <= count_q + {{(DATA_W-1){1'b0}}, pc_we};
      end
   end

   always_comb begin
      state_d   = state_q;
      ctl_d     = ctl_q;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      rf_we     = 1'b0;
      flag_we   = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      halted    = 1'b0;
      error     = 1'b0;
      tmo_clear = 1'b1;
      tmo_en    = 1'b0;
      unique case (state_q)
         StIdle: state_d = StFetch;
         StFetch: begin
            ir_we   = 1'b1;
            state_d = StDecode;
         end
         StDecode: begin
            ctl_d.memr     = memr;
            ctl_d.memw     = memw;
            ctl_d.regw_en  = regw_en;
            ctl_d.upd_flag = upd_flag;
            ctl_d.b        = b;
            ctl_d.jmp      = jmp;
            ctl_d.hlt      = hlt;
            if (hlt) begin
               state_d = StHalt;
            end else if (memr && memw) begin
               state_d = StError;
            end else begin
               state_d = StExec;
            end
         end
         StExec: begin
            flag_we = ctl_q.upd_flag;
            if (ctl_q.memr || ctl_q.memw) begin
               state_d = StMem;
            end else if (ctl_q.regw_en) begin
               state_d = StWb;
            end else begin
               pc_we   = 1'b1;
               state_d = StFetch;
            end
         end
         StMem: begin
            mem_req   = 1'b1;
            mem_we    = ctl_q.memw;
            tmo_clear = 1'b0;
            tmo_en    = !mem_ready;
            // mem_ready is checked first so a completion always beats the timeout.
            if (mem_ready) begin
               if (ctl_q.memw) begin
                  pc_we   = 1'b1;
                  state_d = StFetch;
               end else begin
                  state_d = StWb;
               end
            end else if (tmo_expired) begin
               state_d = StError;
            end
         end
         StWb: begin
            rf_we   = ctl_q.regw_en;
            pc_we   = 1'b1;
            state_d = StFetch;
         end
         StHalt: begin
            halted = 1'b1;
            if (resume) begin
               pc_we   = 1'b1;
               state_d = StFetch;
            end
         end
         StError: error = 1'b1;
      endcase
   end

   // b/jmp are latched for debug visibility only; the datapath picks the next-PC source.
   assign unused_ctl  = ctl_q.b ^ ctl_q.jmp;
   assign state       = state_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: instruction-level expectation model plus per-cycle compare.
module tb_multicycle_sequencer;

   localparam int unsigned Tmo  = 4;
   localparam logic [6:0]  Junk = 7'h7f;
   localparam logic [2:0]  SIdle = 3'd0, SFetch = 3'd1, SDecode = 3'd2, SExec = 3'd3;
   localparam logic [2:0]  SMem = 3'd4, SWb = 3'd5, SHalt = 3'd6, SError = 3'd7;

   logic        clk, rst;
   logic        memr, memw, regw_en, upd_flag, b, jmp, hlt, mem_ready, resume;
   logic        ir_we, pc_we, rf_we, flag_we, mem_req, mem_we, halted, error;
   logic [2:0]  state;
   logic [15:0] instr_count;

   // Expected vector: {state, ir, pc, rf, flag, mem_req, mem_we, halted, error, count}
   logic [26:0] exp_q[$];
   logic [15:0] m_count;
   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc_no   = 0;

   multicycle_sequencer #(
      .MEM_TIMEOUT(Tmo)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .memr       (memr),
      .memw       (memw),
      .regw_en    (regw_en),
      .upd_flag   (upd_flag),
      .b          (b),
      .jmp        (jmp),
      .hlt        (hlt),
      .mem_ready  (mem_ready),
      .resume     (resume),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .rf_we      (rf_we),
      .flag_we    (flag_we),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .halted     (halted),
      .error      (error),
      .state      (state),
      .instr_count(instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, req);
   endtask

   function automatic logic [7:0] outs();
      return {ir_we, pc_we, rf_we, flag_we, mem_req, mem_we, halted, error};
   endfunction

   always @(negedge clk) begin
      logic [26:0] e;
      cyc_no++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check($sformatf("cycle%0d", cyc_no), {5'd0, state, outs(), instr_count}, {5'd0, e});
      end
   end

   // One clock cycle: drive inputs just after the edge and queue what the outputs must be.
   task automatic step(input logic [6:0] c, input logic rdy, input logic res,
                       input logic [2:0] st, input logic [7:0] en);
      @(posedge clk);
      #1;
      {memr, memw, regw_en, upd_flag, b, jmp, hlt} = c;
      mem_ready = rdy;
      resume    = res;
      exp_q.push_back({st, en, m_count});
      if (en[6]) m_count = m_count + 16'd1;
   endtask

   // Whole instruction from FETCH; controls are valid only in DECODE, junk elsewhere.
   task automatic issue(input logic [6:0] c, input int w, input int hwait, input bit preload,
                        output int cycles);
      logic mr, mw, rg, up, hl;
      mr = c[6];
      mw = c[5];
      rg = c[4];
      up = c[3];
      hl = c[0];
      cycles = 2;
      step(Junk, 1'b1, 1'b1, SFetch, 8'h80);
      step(c, 1'b0, 1'b1, SDecode, 8'h00);
      if (hl) begin
         for (int i = 0; i < hwait; i++) begin
            if (preload && i == 1) begin
               @(negedge clk);
               #1;
               force dut.count_q = 16'hffff;
               m_count = 16'hffff;
            end
            step(Junk, 1'b1, 1'b0, SHalt, 8'h02);
            if (preload && i == 1) release dut.count_q;
         end
         step(Junk, 1'b1, 1'b1, SHalt, 8'h42);
         cycles += hwait + 1;
         return;
      end
      if (mr && mw) begin
         for (int i = 0; i < 4; i++) step(Junk, 1'b1, 1'b1, SError, 8'h01);
         cycles += 4;
         return;
      end
      step(Junk, 1'b1, 1'b1, SExec, {1'b0, !(mr || mw) && !rg, 1'b0, up, 4'h0});
      cycles++;
      if (mr || mw) begin
         for (int k = 1; k <= w; k++) begin
            step(Junk, 1'b0, 1'b1, SMem, {4'h0, 1'b1, mw, 2'b00});
            cycles++;
            if (Tmo != 0 && k == Tmo) begin
               for (int i = 0; i < 3; i++) step(Junk, 1'b1, 1'b1, SError, 8'h01);
               cycles += 3;
               return;
            end
         end
         step(Junk, 1'b1, 1'b1, SMem, {1'b0, mw, 2'b00, 1'b1, mw, 2'b00});
         cycles++;
         if (mw) return;
      end else if (!rg) begin
         return;
      end
      step(Junk, 1'b1, 1'b1, SWb, {2'b01, rg, 5'h00});
      cycles++;
   endtask

   task automatic reset_check(input string tag);
      rst = 1'b1;
      exp_q.delete();
      #1;
      check({tag, "_state"}, {29'd0, state}, 32'd0);
      check({tag, "_outs"}, {24'd0, outs()}, 32'd0);
      check({tag, "_count"}, {16'd0, instr_count}, 32'd0);
   endtask

   task automatic release_rst();
      @(posedge clk);
      #1;
      rst     = 1'b0;
      m_count = 16'd0;
      exp_q.push_back({SIdle, 8'h00, 16'd0});
   endtask

   initial begin
      int cyc;
      rst = 1'b1;
      {memr, memw, regw_en, upd_flag, b, jmp, hlt} = '0;
      mem_ready = 1'b0;
      resume    = 1'b0;
      m_count   = 16'd0;
      #2;
      reset_check("por");
      release_rst();

      issue(7'b0011000, 0, 0, 1'b0, cyc);   // ALU, regw + upd_flag
      check("alu_latency", cyc, 32'd4);
      check("alu_count", {16'd0, m_count}, 32'd1);
      issue(7'b1010000, 3, 0, 1'b0, cyc);   // load, 3 stalls
      check("load_latency", cyc, 32'd8);
      issue(7'b0000010, 0, 0, 1'b0, cyc);   // jmp
      check("jmp_latency", cyc, 32'd3);
      issue(7'b0100000, 1, 0, 1'b0, cyc);   // store, 1 stall
      check("store_latency", cyc, 32'd5);
      issue(7'b0001100, 0, 0, 1'b0, cyc);   // branch with flag update
      check("branch_latency", cyc, 32'd3);
      issue(7'b0000001, 0, 5, 1'b0, cyc);   // halt, resume after 5 cycles
      check("halt_latency", cyc, 32'd8);
      check("halt_count", {16'd0, m_count}, 32'd6);
      issue(7'b0000001, 0, 3, 1'b1, cyc);   // halt with count preset to ffff
      check("wrap_count", {16'd0, m_count}, 32'd0);
      issue(7'b0011000, 0, 0, 1'b0, cyc);
      check("post_wrap_count", {16'd0, m_count}, 32'd1);

      issue(7'b1100000, 0, 0, 1'b0, cyc);   // memr & memw together
      #1;
      check("err_flag", {31'd0, error}, 32'd1);
      check("err_state", {29'd0, state}, 32'd7);
      reset_check("err_rst");
      release_rst();

      issue(7'b1010000, 10, 0, 1'b0, cyc);  // load that never completes
      check("tmo_latency", cyc, 32'd10);
      #1;
      check("tmo_flag", {31'd0, error}, 32'd1);
      reset_check("tmo_rst");
      release_rst();

      step(Junk, 1'b1, 1'b1, SFetch, 8'h80);
      step(7'b1010000, 1'b0, 1'b1, SDecode, 8'h00);
      step(Junk, 1'b1, 1'b1, SExec, 8'h00);
      step(Junk, 1'b0, 1'b1, SMem, 8'h08);
      #1;
      check("mid_mem_req", {31'd0, mem_req}, 32'd1);
      reset_check("mid_mem_rst");
      release_rst();
      issue(7'b0011000, 0, 0, 1'b0, cyc);
      @(negedge clk);
      @(negedge clk);
      #1;
      check("queue_drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
